// File: rtl/ariane_soc_pkg.sv
// ariane_soc: shared SoC constants, the redirect command FSM state type and the target-beat helper
package ariane_soc;
  localparam logic [63:0] ERROR_REDIRECT      = 64'h0000_0000_4552_5244;
  localparam logic [63:0] ERROR_REDIRECT_STOP = 64'h0000_0000_5354_4f50;
  typedef enum logic [2:0] {
    RC_IDLE,
    RC_SEND_HDR,
    RC_SEND_TGT,
    RC_HOLD,
    RC_SEND_STOP
  } redirect_cmd_state_e;
  function automatic logic [63:0] redirect_tgt_beat(input logic [31:0] tgt);
    return {tgt, 32'h0};
  endfunction
endpackage

// File: rtl/redirect_cmd_gen.sv
// redirect_cmd_gen: turns redirect/stop requests into the header, target and stop beats for the redirect monitors
module redirect_cmd_gen
  import ariane_soc::*;
#(
  parameter int unsigned N_TARG_PORT   = 7,
  parameter int unsigned AXI_DATA_W    = 64,
  parameter int unsigned LOG_N_INIT    = 2,
  parameter int unsigned AUTO_STOP_CYC = 0,
  localparam int unsigned PW = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1,
  localparam int unsigned CW = (AUTO_STOP_CYC > 0) ? $clog2(AUTO_STOP_CYC + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_stop_i,
  input  logic [PW-1:0]         req_port_i,
  input  logic [LOG_N_INIT-1:0] req_target_i,
  output logic [AXI_DATA_W-1:0] wdata_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [PW-1:0]         port_sel_o,
  output logic [N_TARG_PORT-1:0] active_o,
  output logic                  busy_o
);
  localparam logic [CW-1:0] CNT_LAST = CW'(AUTO_STOP_CYC > 0 ? AUTO_STOP_CYC - 1 : 0);
  redirect_cmd_state_e state_q, state_d;
  logic [PW-1:0]          cur_port_q, cur_port_d, port_sel_q, port_sel_d;
  logic [LOG_N_INIT-1:0]  cur_tgt_q, cur_tgt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AXI_DATA_W-1:0]  wdata_q, wdata_d;
  logic                   wvalid_q, wvalid_d, busy_q, busy_d;
  logic [N_TARG_PORT-1:0] active_q, active_d;
  logic                   port_ok, accept, hs;
  assign port_ok     = 32'(req_port_i) < N_TARG_PORT;
  assign req_ready_o = (state_q == RC_IDLE) || (state_q == RC_HOLD && cnt_q != CNT_LAST);
  assign accept      = req_valid_i && req_ready_o && port_ok;
  assign hs          = wvalid_q && wready_i;
  always_comb begin
    state_d    = state_q;
    cur_port_d = cur_port_q;
    cur_tgt_d  = cur_tgt_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    case (state_q)
      RC_IDLE, RC_HOLD: begin
        if (accept) begin
          cur_port_d = req_port_i;
          cur_tgt_d  = req_stop_i ? cur_tgt_q : req_target_i;
          state_d    = req_stop_i ? RC_SEND_STOP : RC_SEND_HDR;
          cnt_d      = '0;
        end else if (state_q == RC_HOLD) begin
          state_d = (cnt_q == CNT_LAST) ? RC_SEND_STOP : RC_HOLD;
          cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
      end
      RC_SEND_HDR: state_d = hs ? RC_SEND_TGT : state_q;
      RC_SEND_TGT: begin
        if (hs) begin
          active_d[cur_port_q] = 1'b1;
          state_d = (AUTO_STOP_CYC > 0) ? RC_HOLD : RC_IDLE;
          cnt_d   = '0;
        end
      end
      RC_SEND_STOP: begin
        if (hs) begin
          active_d[cur_port_q] = 1'b0;
          state_d = RC_IDLE;
        end
      end
      default: state_d = RC_IDLE;
    endcase
    // beat outputs are decoded from the next state so they register alongside it
    wvalid_d   = state_d inside {RC_SEND_HDR, RC_SEND_TGT, RC_SEND_STOP};
    wdata_d    = (state_d == RC_SEND_HDR)  ? AXI_DATA_W'(ERROR_REDIRECT) :
                 (state_d == RC_SEND_TGT)  ? AXI_DATA_W'(redirect_tgt_beat(32'(cur_tgt_d))) :
                 (state_d == RC_SEND_STOP) ? AXI_DATA_W'(ERROR_REDIRECT_STOP) : '0;
    port_sel_d = cur_port_d;
    busy_d     = state_d != RC_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RC_IDLE;
      cur_port_q <= '0;
      cur_tgt_q  <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      wvalid_q   <= 1'b0;
      port_sel_q <= '0;
      active_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      cur_tgt_q  <= cur_tgt_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      wvalid_q   <= wvalid_d;
      port_sel_q <= port_sel_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && req_valid_i && req_ready_o) assert (port_ok) else $error("illegal req_port_i %0d", req_port_i);
  end
  assign wdata_o    = wdata_q;
  assign wvalid_o   = wvalid_q;
  assign port_sel_o = port_sel_q;
  assign active_o   = active_q;
  assign busy_o     = busy_q;
endmodule

// File: tb/tb_redirect_cmd_gen.sv
// tb_redirect_cmd_gen: transaction-queue model for the no-hold instance, directed timing for the auto-stop instance
module tb_redirect_cmd_gen;
  localparam logic [63:0] HDR = 64'h0000_0000_4552_5244;
  localparam logic [63:0] STP = 64'h0000_0000_5354_4f50;
  typedef struct {int kind; logic [2:0] port; logic [63:0] data;} beat_t;
  logic clk = 1'b0, rst_n;
  logic v0, s0, wr0, rdy0, wv0, busy0, v5, s5, wr5, rdy5, wv5, busy5;
  logic [2:0] p0, ps0, p5, ps5;
  logic [1:0] t0, t5;
  logic [63:0] wd0, wd5;
  logic [6:0] act0, act5;
  int checks = 0, failures = 0;
  bit live = 0;
  beat_t q[$];
  logic [6:0] act = '0;
  always #5 clk = ~clk;
  redirect_cmd_gen #(.N_TARG_PORT(7), .AXI_DATA_W(64), .LOG_N_INIT(2), .AUTO_STOP_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v0), .req_ready_o(rdy0), .req_stop_i(s0), .req_port_i(p0),
    .req_target_i(t0), .wdata_o(wd0), .wvalid_o(wv0), .wready_i(wr0), .port_sel_o(ps0), .active_o(act0),
    .busy_o(busy0));
  redirect_cmd_gen #(.N_TARG_PORT(7), .AXI_DATA_W(64), .LOG_N_INIT(2), .AUTO_STOP_CYC(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v5), .req_ready_o(rdy5), .req_stop_i(s5), .req_port_i(p5),
    .req_target_i(t5), .wdata_o(wd5), .wvalid_o(wv5), .wready_i(wr5), .port_sel_o(ps5), .active_o(act5),
    .busy_o(busy5));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    beat_t b;
    bit acc, hs;
    if (live) begin
      chk("rdy0", rdy0, q.size() == 0);
      chk("wv0", wv0, q.size() != 0);
      if (q.size() != 0) begin
        chk("wd0", wd0, q[0].data);
        chk("ps0", ps0, q[0].port);
      end
    end
    acc = rst_n && v0 && q.size() == 0;
    hs  = rst_n && q.size() != 0 && wr0;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      act = '0;
    end else if (hs) begin
      b = q.pop_front();
      if (b.kind == 1) act[b.port] = 1'b1;
      else if (b.kind == 2) act[b.port] = 1'b0;
    end else if (acc) begin
      if (s0) q.push_back('{kind: 2, port: p0, data: STP});
      else begin
        q.push_back('{kind: 0, port: p0, data: HDR});
        q.push_back('{kind: 1, port: p0, data: {30'h0, t0, 32'h0}});
      end
    end
    @(negedge clk);
    chk("act0", act0, act);
    chk("busy0", busy0, q.size() != 0);
    if (!wv0) chk("idle_zero0", wd0, 0);
    if (!wv5) chk("idle_zero5", wd5, 0);
  endtask
  task automatic req5(input logic stop, input logic [2:0] port, input logic [1:0] tgt);
    v5 = 1'b1; s5 = stop; p5 = port; t5 = tgt;
    chk("rdy5_accept", rdy5, 1);
    cyc();
    v5 = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    {v0, s0, p0, t0, v5, s5, p5, t5} = '0;
    wr0 = 1'b1; wr5 = 1'b1;
    @(negedge clk);
    cyc();
    chk("rst_wv5", wv5, 0); chk("rst_wd5", wd5, 0); chk("rst_ps5", ps5, 0);
    chk("rst_act5", act5, 0); chk("rst_busy5", busy5, 0); chk("rst_rdy5", rdy5, 1);
    chk("rst_ps0", ps0, 0); chk("rst_rdy0", rdy0, 1);
    live = 1;
    rst_n = 1'b1;
    v0 = 1'b1; s0 = 1'b0; p0 = 3'd3; t0 = 2'd2;
    cyc();
    v0 = 1'b0;
    chk("redir_hdr", wd0, HDR);
    cyc();
    chk("redir_tgt", wd0, 64'h00000002_00000000);
    chk("redir_port", ps0, 3);
    cyc();
    chk("redir_active", act0, 7'b0001000);
    v0 = 1'b1; p0 = 3'd0; t0 = 2'd1; wr0 = 1'b0;
    cyc();
    v0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_hdr", wd0, HDR);
      chk("stall_valid", wv0, 1);
      cyc();
    end
    wr0 = 1'b1;
    cyc();
    chk("stall_tgt", wd0, 64'h00000001_00000000);
    cyc();
    v0 = 1'b1; s0 = 1'b1; p0 = 3'd6;
    cyc();
    v0 = 1'b0; s0 = 1'b0;
    chk("stop6_data", wd0, STP);
    chk("stop6_port", ps0, 6);
    cyc();
    chk("stop6_active", act0, 7'b0001001);
    req5(0, 3'd1, 2'd3);
    chk("auto_hdr", wd5, HDR); chk("auto_hdr_v", wv5, 1); chk("auto_hdr_p", ps5, 1);
    cyc();
    chk("auto_tgt", wd5, 64'h00000003_00000000);
    cyc();
    chk("auto_active", act5, 7'b0000010);
    for (int k = 0; k < 5; k++) begin
      chk("hold_rdy", rdy5, k != 4);
      chk("hold_wv", wv5, 0);
      cyc();
    end
    chk("auto_stop_v", wv5, 1); chk("auto_stop_d", wd5, STP); chk("auto_stop_p", ps5, 1);
    chk("auto_stop_act", act5, 7'b0000010);
    cyc();
    chk("auto_cleared", act5, 0); chk("auto_busy", busy5, 0); chk("auto_rdy", rdy5, 1);
    req5(0, 3'd1, 2'd0);
    cyc(); cyc(); cyc(); cyc();
    v5 = 1'b1; s5 = 1'b1; p5 = 3'd1;
    chk("preempt_rdy", rdy5, 1);
    cyc();
    v5 = 1'b0;
    chk("preempt_stop_v", wv5, 1); chk("preempt_stop_d", wd5, STP); chk("preempt_stop_p", ps5, 1);
    cyc();
    chk("preempt_act", act5, 0); chk("preempt_wv", wv5, 0);
    req5(0, 3'd2, 2'd1);
    cyc(); cyc();
    for (int k = 0; k < 4; k++) cyc();
    v5 = 1'b1; s5 = 1'b0; p5 = 3'd4; t5 = 2'd0;
    chk("cnt4_rdy", rdy5, 0);
    cyc();
    v5 = 1'b0;
    chk("cnt4_stop_d", wd5, STP); chk("cnt4_stop_p", ps5, 2);
    cyc();
    chk("cnt4_act", act5, 0); chk("cnt4_busy", busy5, 0);
    for (int i = 0; i < 400; i++) begin
      v0  = $urandom_range(0, 2) == 0;
      s0  = $urandom_range(0, 3) == 0;
      p0  = 3'($urandom_range(0, 6));
      t0  = 2'($urandom_range(0, 3));
      wr0 = $urandom_range(0, 3) != 0;
      cyc();
    end
    v0 = 1'b0; wr0 = 1'b1;
    repeat (4) cyc();
    v0 = 1'b1; s0 = 1'b0; p0 = 3'd5; t0 = 2'd1;
    cyc();
    v0 = 1'b0;
    cyc();
    chk("pre_rst_tgt", wd0, 64'h00000001_00000000);
    rst_n = 1'b0;
    cyc();
    chk("rst_mid_wv", wv0, 0); chk("rst_mid_act", act0, 0);
    rst_n = 1'b1;
    chk("rst_mid_rdy", rdy0, 1);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/redirect_cmd_gen.md
# redirect_cmd_gen

Initiator side of the error-redirect command protocol. Converts a simple request (port, target initiator, start/stop) into the write-data beat sequence that the redirect monitor on each target port decodes: an `ERROR_REDIRECT` header beat followed by a target beat, and later an `ERROR_REDIRECT_STOP` beat. It sits on the SoC security/error-handling path and drives one W-channel-style stream plus a port select. A per-port active vector tracks which ports currently have a redirect in force. An optional hold timer issues STOP automatically.

## Interface
- `N_TARG_PORT`, 7: number of target ports that can be addressed.
- `AXI_DATA_W`, 64: data beat width. Fixed at 64; the target field sits in [63:32].
- `LOG_N_INIT`, 2: width of the target-initiator field.
- `AUTO_STOP_CYC`, 0: hold cycles before an automatic STOP. 0 disables auto-stop.
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset. Synchronous, active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when both `req_valid_i` and `req_ready_o` are 1 at a rising edge.
- `req_stop_i` in 1: 1 selects a STOP request; 0 selects a redirect request.
- `req_port_i` in $clog2(N_TARG_PORT): target port index. Values ≥ N_TARG_PORT are illegal; they are asserted against and never accepted.
- `req_target_i` in LOG_N_INIT: redirect target initiator. Ignored for STOP requests.
- `wdata_o` out AXI_DATA_W: command beat.
- `wvalid_o` out 1: beat valid.
- `wready_i` in 1: beat accepted.
- `port_sel_o` out $clog2(N_TARG_PORT): port the current beat is routed to.
- `active_o` out N_TARG_PORT: per-port flag, 1 while a redirect is in force on that port.
- `busy_o` out 1: 1 whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, SEND_HDR, SEND_TGT, HOLD and SEND_STOP.
- Requests are latched on acceptance: port into `cur_port` and target into `cur_tgt`.
- IDLE:
  - `req_ready_o` is 1.
  - An accepted redirect request goes to SEND_HDR.
  - An accepted STOP request goes to SEND_STOP.
- SEND_HDR:
  - `wdata_o` = `ERROR_REDIRECT`, `wvalid_o` = 1.
  - On handshake, go to SEND_TGT.
- SEND_TGT:
  - `wdata_o` = {32'(cur_tgt) zero-extended, 32'h0}, `wvalid_o` = 1.
  - On handshake, set `active_o[cur_port]`.
  - On handshake, go to HOLD if `AUTO_STOP_CYC` > 0, otherwise to IDLE.
- HOLD:
  - The counter starts at 0 and increments each cycle.
  - `req_ready_o` = 1 except in the cycle where count == AUTO_STOP_CYC-1.
  - When count reaches AUTO_STOP_CYC-1, go to SEND_STOP with `cur_port` unchanged.
  - An accepted request preempts the timer: the counter is cleared and the request is handled as in IDLE. The previous redirect stays active until an explicit STOP.
- SEND_STOP:
  - `wdata_o` = `ERROR_REDIRECT_STOP`, `wvalid_o` = 1.
  - On handshake, clear `active_o[cur_port]` and go to IDLE.
  - A STOP to an inactive port is still sent; `active_o` stays 0.
- Handshake rules:
  - Once `wvalid_o` is 1, it and `wdata_o`/`port_sel_o` are held stable until `wready_i` is 1.
  - `req_ready_o` is 0 in all SEND_* states.
- Whenever `wvalid_o` is 0, `wdata_o` is 64'h0. The receiver matches STOP without qualifying on valid, so an idle bus must never carry the STOP word.
- A redirect to an already-active port re-sends the header and target beats; `active_o` stays 1.

## Timing
- All outputs are registered except `req_ready_o`, which is decoded from state and counter.
- Reset values: `wvalid_o` 0, `wdata_o` 0, `port_sel_o` 0, `active_o` 0, `busy_o` 0, state IDLE, counter 0. `req_ready_o` is 1 in the first cycle after reset.
- A request accepted at edge E puts the header valid from E+1.
- With `wready_i` tied to 1:
  - header handshake at E+1, target at E+2, `active_o` set after E+2.
  - auto-stop: STOP is valid at E+3+AUTO_STOP_CYC.
  - STOP request: the STOP beat is valid from E+1.
- Back-to-back requests are allowed: IDLE accepts in the same cycle the FSM returns to IDLE.
- Reset asserted mid-sequence returns everything to reset values at the next edge, including dropping `wvalid_o` mid-beat. The receiver shares `rst_n`, so no partial sequence survives.

## Structure
- `ERROR_REDIRECT` and `ERROR_REDIRECT_STOP` come from the `ariane_soc` package and are not duplicated locally.
- Add to `ariane_soc`: a `redirect_cmd_state_e` enum for the FSM, and a helper function that builds the target beat.
- Single module; no sub-module. The hold counter is inline, with width $clog2(AUTO_STOP_CYC+1), minimum 1.

## Test plan
- Redirect port 3 to target 2, `wready_i`=1: beats on port 3 are `ERROR_REDIRECT`, then 64'h00000002_00000000; `active_o`=7'b0001000.
- `wready_i` held 0 for 4 cycles during the header: `wvalid_o` stays 1 and `wdata_o` stays stable; no target beat appears before the header handshake.
- `AUTO_STOP_CYC`=5, redirect port 1 accepted at E: STOP is valid on port 1 at E+8; `active_o[1]` clears after its handshake.
- `AUTO_STOP_CYC`=5: a STOP request for port 1 in HOLD cycle 2 is accepted and the STOP is sent immediately. A request presented at count 4 is not accepted (`req_ready_o`=0) and the auto-stop fires instead.
- STOP to inactive port 6: one STOP beat is sent and `active_o` stays 0. `wdata_o` reads 0 in every cycle where `wvalid_o` is 0.
- `rst_n` low during SEND_TGT: the next cycle has `wvalid_o`=0 and `active_o`=0, and `req_ready_o`=1 once `rst_n` is high.
